fetch_pfq: RTL and testbench

Parametrised instruction fetch stage with a prefetch queue. It runs its own fetch PC and issues IFU reads ahead of the pipeline. Returned instructions are buffered in a DEPTH-entry FIFO, so decode can consume one per cycle while exec/mem stall. It sits between the IFU and decode, replacing the single-register fetch stage, and adds jump flush, per-entry PC tracking and fetch-error reporting.

---
 rtl/fetch_pfq.sv | 203 ++++++++++++++++++++
 tb/tb_fetch_pfq.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pfq.sv
// fetch_pfq: instruction fetch stage with a DEPTH-entry prefetch queue.
// Runs its own fetch PC, keeps at most one IFU read in flight and buffers the
// returned instructions so decode can drain one per cycle while exec/mem stall.
// Optional feature macro: FETCH_BYPASS_EN. When defined, a clean response that
// arrives while the queue is empty and decode is not stalled is forwarded to
// decode in the same cycle instead of being enqueued.
module fetch_pfq #(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           INSTR_WIDTH = 32,
   parameter int unsigned           DEPTH       = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic                   i_jump_valid,
   input  logic [ADDR_WIDTH-1:0]  i_jump_addr,
   input  logic                   i_stall,
   output logic                   o_fetch_stall,
   output logic                   o_fetch_except,
   output logic [INSTR_WIDTH-1:0] o_instr,
   output logic [ADDR_WIDTH-1:0]  o_instr_pc,
   output logic                   o_instr_valid,
   output logic [ADDR_WIDTH-1:0]  o_addr,
   output logic                   o_rd_cmd,
   input  logic [INSTR_WIDTH-1:0] i_instr_dat,
   input  logic                   i_busy,
   input  logic                   i_err_align,
   input  logic                   i_err_bus
);

   localparam int unsigned      PTR_W   = $clog2(DEPTH);
   localparam int unsigned      CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [0:0] {StIdle, StWait} rd_state_e;

   rd_state_e              state_q, state_d;
   logic                   outstanding;
   logic [ADDR_WIDTH-1:0]  fpc_q, fpc_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic                   rd_cmd_q, rd_cmd_d;
   logic                   drop_q, drop_d;
   logic                   halted_q, halted_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       count_q, count_d;

   logic [INSTR_WIDTH-1:0] mem_dat [DEPTH];
   logic [ADDR_WIDTH-1:0]  mem_pc  [DEPTH];
   logic                   mem_err [DEPTH];

   logic                   completion;
   logic                   err_in;
   logic                   empty;
   logic                   head_err;
   logic                   push;
   logic                   pop;
   logic                   issue;
`ifdef FETCH_BYPASS_EN
   logic                   bypass_take;
`endif

   // Handshake and queue-control decode
   always_comb begin
      // The cycle carrying the read strobe can never complete the read.
      completion = outstanding && !rd_cmd_q && !i_busy;
      err_in     = i_err_align | i_err_bus;
      empty      = (count_q == '0);
      head_err   = !empty && mem_err[rd_ptr_q];
      // An error entry parks at the head until a jump flushes it.
      pop        = !i_stall && !empty && !head_err;
      issue      = !outstanding && !halted_q && !i_jump_valid &&
                   ((count_q + CNT_W'(outstanding)) < DEPTH_C);
`ifdef FETCH_BYPASS_EN
      bypass_take = empty && completion && !err_in && !drop_q && !i_stall && !i_jump_valid;
      push        = completion && !drop_q && !i_jump_valid && !bypass_take;
`else
      push        = completion && !drop_q && !i_jump_valid;
`endif
   end

   // Read-tracking state register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Read-tracking next state: a jump does not cancel the IFU transaction
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (issue)      state_d = StWait;
         StWait:  if (completion) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Read-tracking output
   always_comb begin
      outstanding = (state_q == StWait);
   end

   // Fetch PC, IFU request and queue pointer next state; jump has priority
   always_comb begin
      fpc_d    = fpc_q;
      addr_d   = addr_q;
      rd_cmd_d = 1'b0;
      drop_d   = drop_q;
      halted_d = halted_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (i_jump_valid) begin
         fpc_d    = i_jump_addr;
         halted_d = 1'b0;
         // A read still in flight after this cycle belongs to the old path.
         drop_d   = outstanding && !completion;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (completion) begin
            drop_d = 1'b0;
         end
         if (push && err_in) begin
            halted_d = 1'b1;
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
         if (issue) begin
            addr_d   = fpc_q;
            fpc_d    = fpc_q + ADDR_WIDTH'(4);
            rd_cmd_d = 1'b1;
         end
      end
   end

   // Control state registers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         fpc_q    <= RESET_PC;
         addr_q   <= '0;
         rd_cmd_q <= 1'b0;
         drop_q   <= 1'b0;
         halted_q <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         fpc_q    <= fpc_d;
         addr_q   <= addr_d;
         rd_cmd_q <= rd_cmd_d;
         drop_q   <= drop_d;
         halted_q <= halted_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Queue storage; contents are only meaningful below count_q
   always_ff @(posedge clk) begin
      if (push) begin
         mem_dat[wr_ptr_q] <= i_instr_dat;
         mem_pc[wr_ptr_q]  <= addr_q;
         mem_err[wr_ptr_q] <= err_in;
      end
   end

   // Decode-facing outputs from the queue head (NOP when nothing valid)
   always_comb begin
      o_instr        = '0;
      o_instr_pc     = '0;
      o_instr_valid  = 1'b0;
      o_fetch_except = 1'b0;
      if (!empty) begin
         o_instr_pc = mem_pc[rd_ptr_q];
         if (head_err) begin
            o_fetch_except = 1'b1;
         end else begin
            o_instr       = mem_dat[rd_ptr_q];
            o_instr_valid = 1'b1;
         end
      end
`ifdef FETCH_BYPASS_EN
      if (bypass_take) begin
         o_instr       = i_instr_dat;
         o_instr_pc    = addr_q;
         o_instr_valid = 1'b1;
      end
`endif
      o_fetch_stall = !o_instr_valid;
   end

   assign o_addr   = addr_q;
   assign o_rd_cmd = rd_cmd_q;

endmodule

// File: tb/tb_fetch_pfq.sv
// tb_fetch_pfq: directed bench for fetch_pfq with a transaction-level model
// (queue of fetched entries plus fetch PC) checked against the DUT each cycle.
module tb_fetch_pfq;

   localparam int unsigned AW    = 32;
   localparam int unsigned IW    = 32;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          nrst;
   logic          i_jump_valid;
   logic [AW-1:0] i_jump_addr;
   logic          i_stall;
   logic          i_busy = 1'b0;
   logic          i_err_align;
   logic          i_err_bus;
   logic [IW-1:0] i_instr_dat;
   logic          o_fetch_stall;
   logic          o_fetch_except;
   logic [IW-1:0] o_instr;
   logic [AW-1:0] o_instr_pc;
   logic          o_instr_valid;
   logic [AW-1:0] o_addr;
   logic          o_rd_cmd;

   int checks = 0;
   int errors = 0;

   // IFU responder knobs
   int            busy_len     = 0;
   bit            busy_hold    = 1'b0;
   int            bcnt         = 0;
   bit            err_bus_en   = 1'b0;
   bit            err_align_en = 1'b0;
   logic [AW-1:0] err_addr     = '0;

   function automatic logic [IW-1:0] dat_of(input logic [AW-1:0] a);
      return a + 32'h1300_0013;
   endfunction

   assign i_instr_dat = dat_of(o_addr);
   assign i_err_bus   = err_bus_en && (o_addr == err_addr);
   assign i_err_align = err_align_en && (o_addr == err_addr);

   fetch_pfq #(
      .ADDR_WIDTH  (AW),
      .INSTR_WIDTH (IW),
      .DEPTH       (DEPTH),
      .RESET_PC    (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .nrst           (nrst),
      .i_jump_valid   (i_jump_valid),
      .i_jump_addr    (i_jump_addr),
      .i_stall        (i_stall),
      .o_fetch_stall  (o_fetch_stall),
      .o_fetch_except (o_fetch_except),
      .o_instr        (o_instr),
      .o_instr_pc     (o_instr_pc),
      .o_instr_valid  (o_instr_valid),
      .o_addr         (o_addr),
      .o_rd_cmd       (o_rd_cmd),
      .i_instr_dat    (i_instr_dat),
      .i_busy         (i_busy),
      .i_err_align    (i_err_align),
      .i_err_bus      (i_err_bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: fetched-but-unconsumed entries in order, plus the fetch front end
   typedef struct {
      logic [IW-1:0] dat;
      logic [AW-1:0] pc;
      bit            err;
   } ent_t;

   ent_t          m_q[$];
   logic [AW-1:0] m_fpc    = '0;
   logic [AW-1:0] m_addr   = '0;
   bit            m_out    = 1'b0;
   bit            m_cmd    = 1'b0;
   bit            m_drop   = 1'b0;
   bit            m_halted = 1'b0;
   logic [AW-1:0] dlog[$];

   // Compare on the falling edge, then advance the model one cycle
   always @(negedge clk) begin : model_cmp
      logic [IW-1:0] e_instr;
      logic [AW-1:0] e_pc;
      bit            e_valid, e_exc, comp, pop, iss, err;
      int            cnt;
      if (!nrst) begin
         m_q.delete();
         m_fpc = '0; m_addr = '0; m_out = 0; m_cmd = 0; m_drop = 0; m_halted = 0;
      end
      e_instr = '0; e_pc = '0; e_valid = 0; e_exc = 0;
      if (m_q.size() > 0) begin
         e_pc = m_q[0].pc;
         if (m_q[0].err) e_exc = 1;
         else begin
            e_instr = m_q[0].dat;
            e_valid = 1;
         end
      end
      check("rd_cmd", 64'(o_rd_cmd), 64'(m_cmd));
      check("addr", 64'(o_addr), 64'(m_addr));
      check("instr", 64'(o_instr), 64'(e_instr));
      check("instr_pc", 64'(o_instr_pc), 64'(e_pc));
      check("instr_valid", 64'(o_instr_valid), 64'(e_valid));
      check("fetch_stall", 64'(o_fetch_stall), 64'(!e_valid));
      check("fetch_except", 64'(o_fetch_except), 64'(e_exc));
      if (o_instr_valid && !i_stall) dlog.push_back(o_instr_pc);
      if (nrst) begin
         cnt  = m_q.size();
         comp = m_out && !m_cmd && !i_busy;
         err  = (err_bus_en || err_align_en) && (m_addr == err_addr);
         pop  = !i_stall && cnt > 0 && !m_q[0].err;
         if (i_jump_valid) begin
            m_q.delete();
            m_halted = 0;
            m_fpc    = i_jump_addr;
            m_drop   = m_out && !comp;
            m_out    = m_out && !comp;
            m_cmd    = 0;
         end else begin
            iss = !m_out && !m_halted && cnt < DEPTH;
            if (pop) void'(m_q.pop_front());
            if (comp) begin
               m_out = 0;
               if (m_drop) m_drop = 0;
               else begin
                  m_q.push_back('{dat: dat_of(m_addr), pc: m_addr, err: err});
                  if (err) m_halted = 1;
               end
            end
            if (iss) begin
               m_addr = m_fpc;
               m_fpc  = m_fpc + 32'd4;
               m_out  = 1;
               m_cmd  = 1;
            end else m_cmd = 0;
         end
      end
   end

   // IFU responder: busy for busy_len cycles after each strobe, or while held
   always @(posedge clk) begin
      #2;
      if (o_rd_cmd) begin
         bcnt   = busy_len;
         i_busy = busy_hold;
      end else begin
         i_busy = busy_hold || (bcnt > 0);
         if (bcnt > 0) bcnt--;
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic bit sig(input int sel);
      case (sel)
         0:       return o_rd_cmd;
         1:       return o_fetch_except;
         2:       return o_instr_valid;
         default: return m_out && !m_cmd;
      endcase
   endfunction

   task automatic wait_until(input string name, input int sel, input int lim);
      int k = 0;
      while (!sig(sel) && k < lim) begin
         cyc(1);
         k++;
      end
      if (!sig(sel)) begin
         checks++;
         errors++;
         $display("FAIL %s: event not seen after %0d cycles, required within %0d", name, k, lim);
      end
   endtask

   task automatic check_run(input string name, input int from, input int n);
      check({name, "_len"}, 64'(dlog.size() >= from + n), 64'd1);
      for (int i = 1; i < n && from + i < dlog.size(); i++)
         check({name, "_order"}, 64'(dlog[from+i]), 64'(dlog[from+i-1] + 32'd4));
   endtask

   initial begin : main
      int mark, ncmd;
      logic [AW-1:0] first_addr;
      nrst = 1'b0; i_jump_valid = 1'b0; i_jump_addr = '0; i_stall = 1'b0;
      #200000;
      $display("FAIL watchdog: simulation time %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int mark, ncmd;
      cyc(3);
      // Reset values
      check("rst_stall", 64'(o_fetch_stall), 64'd1);
      check("rst_valid", 64'(o_instr_valid), 64'd0);
      check("rst_rd_cmd", 64'(o_rd_cmd), 64'd0);
      nrst = 1'b1;

      // Free-running fetch
      cyc(1);
      wait_until("first_cmd", 0, 10);
      check("first_addr", 64'(o_addr), 64'h0);
      cyc(20);
      check("run_len", 64'(dlog.size() >= 3), 64'd1);
      if (dlog.size() >= 3) begin
         check("run_pc0", 64'(dlog[0]), 64'h0);
         check("run_pc1", 64'(dlog[1]), 64'h4);
         check("run_pc2", 64'(dlog[2]), 64'h8);
      end

      // Stall until full: reads stop, then four back-to-back deliveries
      i_stall = 1'b1;
      cyc(14);
      ncmd = 0;
      repeat (6) begin
         cyc(1);
         ncmd += int'(o_rd_cmd);
      end
      check("full_no_cmd", 64'(ncmd), 64'd0);
      i_stall = 1'b0;
      mark = dlog.size();
      cyc(4);
      check("drain_count", 64'(dlog.size() - mark), 64'd4);
      check_run("drain", mark, 4);

      // Back-to-back jumps while a slow read is in flight
      busy_len = 3;
      cyc(1);
      wait_until("jmp_cmd", 0, 20);
      i_jump_valid = 1'b1; i_jump_addr = 32'h300;
      cyc(1);
      i_jump_addr = 32'h100;
      cyc(1);
      i_jump_valid = 1'b0; busy_len = 0;
      err_addr = 32'h108; err_bus_en = 1'b1;
      mark = dlog.size();
      wait_until("jmp_new_cmd", 0, 20);
      check("jmp_new_addr", 64'(o_addr), 64'h100);

      // Bus error at 0x108: two good entries, then a parked exception
      wait_until("err_except", 1, 40);
      check("err_instr", 64'(o_instr), 64'h0);
      check("err_valid", 64'(o_instr_valid), 64'd0);
      check("err_pc", 64'(o_instr_pc), 64'h108);
      check("err_delivered", 64'(dlog.size() - mark), 64'd2);
      if (dlog.size() >= mark + 2) begin
         check("jmp_first_pc", 64'(dlog[mark]), 64'h100);
         check("jmp_second_pc", 64'(dlog[mark+1]), 64'h104);
      end
      ncmd = 0;
      repeat (10) begin
         cyc(1);
         ncmd += int'(o_rd_cmd);
      end
      check("halted_no_cmd", 64'(ncmd), 64'd0);
      check("halted_except", 64'(o_fetch_except), 64'd1);
      i_jump_valid = 1'b1; i_jump_addr = 32'h200; err_bus_en = 1'b0;
      cyc(1);
      i_jump_valid = 1'b0;
      check("except_cleared", 64'(o_fetch_except), 64'd0);
      wait_until("restart_valid", 2, 20);
      check("restart_pc", 64'(o_instr_pc), 64'h200);
      check("restart_instr", 64'(o_instr), 64'(dat_of(32'h200)));

      // Three queued plus one in flight; complete and pop in the same cycle
      i_stall = 1'b1;
      begin : fill_wait
         int k = 0;
         while (!(m_q.size() == 3 && m_cmd) && k < 60) begin
            cyc(1);
            k++;
         end
         check("fill_reached", 64'(m_q.size() == 3 && m_cmd), 64'd1);
      end
      busy_hold = 1'b1;
      cyc(3);
      i_stall = 1'b0; busy_hold = 1'b0;
      mark = dlog.size();
      cyc(1);
      i_stall = 1'b1;
      cyc(8);
      i_stall = 1'b0;
      cyc(12);
      if (dlog.size() > mark) check("full_first_pc", 64'(dlog[mark]), 64'h200);
      check_run("full", mark, 6);

      // Asynchronous reset while a read is pending
      busy_hold = 1'b1;
      wait_until("hold_wait", 3, 30);
      nrst = 1'b0;
      #1;
      check("arst_rd_cmd", 64'(o_rd_cmd), 64'd0);
      check("arst_addr", 64'(o_addr), 64'h0);
      check("arst_valid", 64'(o_instr_valid), 64'd0);
      check("arst_stall", 64'(o_fetch_stall), 64'd1);
      check("arst_pc", 64'(o_instr_pc), 64'h0);
      check("arst_instr", 64'(o_instr), 64'h0);
      check("arst_except", 64'(o_fetch_except), 64'd0);
      busy_hold = 1'b0;
      cyc(2);
      err_addr = 32'h4; err_align_en = 1'b1;
      nrst = 1'b1;
      cyc(1);
      wait_until("post_rst_cmd", 0, 10);
      check("post_rst_addr", 64'(o_addr), 64'h0);

      // Misaligned-address error at 0x4
      wait_until("align_except", 1, 30);
      check("align_pc", 64'(o_instr_pc), 64'h4);
      check("align_instr", 64'(o_instr), 64'h0);
      check("align_stall", 64'(o_fetch_stall), 64'd1);
      cyc(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
